// File: rtl/peribus_hub.sv
// Peribus hub: decodes host accesses into per-slot chipselect/strobe windows with a ready
// timeout, and hosts a small control block for interrupt pending/mask and bus-error status.
module peribus_hub #(
    parameter int NUM_SLOTS      = 8,
    parameter int SLOT_ADDR_BITS = 2,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int CTRL_BASE      = 'hF0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                            CLOCK_50,
    input  logic                            reset_n,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           write_data,
    input  logic                            write_enable,
    input  logic                            read_enable,
    output logic [DATA_WIDTH-1:0]           read_data,
    output logic                            ready,
    output logic                            error,
    output logic                            irq,
    output logic [SLOT_ADDR_BITS-1:0]       peri_addr,
    output logic [DATA_WIDTH-1:0]           peri_write_data,
    output logic                            peri_write_en,
    output logic                            peri_read_en,
    output logic [NUM_SLOTS-1:0]            peri_chipselect,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] peri_read_data,
    input  logic [NUM_SLOTS-1:0]            peri_ready,
    input  logic [NUM_SLOTS-1:0]            peri_irq
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = ADDR_WIDTH - SLOT_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          count_q;
    logic [ADDR_WIDTH-1:0]     capAddr_q, errAddr_q, errAddr_d;
    logic [NUM_SLOTS-1:0]      pending_q, pending_d, mask_q, irqPrev_q, chipSel_q;
    logic [2:0]                status_q, status_d;
    logic [DATA_WIDTH-1:0]     readData_q, periWdata_q;
    logic [SLOT_ADDR_BITS-1:0] periAddr_q;
    logic                      ready_q, error_q, periWen_q, periRen_q;

    logic [IDX_W-1:0]          slotIdx;
    logic [NUM_SLOTS-1:0]      slotOneHot, pendClr;
    logic                      idle, slotHit, ctrlHit, singleReq, bothReq;
    logic                      ctrlWrite, maskWrite, slotReady, timeoutHit;
    logic [1:0]                ctrlSel;
    logic [2:0]                statClr, statSet;
    logic [DATA_WIDTH-1:0]     ctrlRdata, slotRdata;

    always_comb begin
        idle       = (state_q == IDLE);
        singleReq  = read_enable ^ write_enable;
        bothReq    = read_enable & write_enable;
        slotIdx    = addr[ADDR_WIDTH-1:SLOT_ADDR_BITS];
        slotHit    = (int'(slotIdx) < NUM_SLOTS);
        slotOneHot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (int'(slotIdx) == i) slotOneHot[i] = 1'b1;
        end
        ctrlHit    = (int'(addr) >= CTRL_BASE) && (int'(addr) < CTRL_BASE + 4);
        ctrlSel    = 2'(int'(addr) - CTRL_BASE);
        ctrlWrite  = idle && singleReq && write_enable && ctrlHit && !slotHit;
        maskWrite  = ctrlWrite && (ctrlSel == 2'd1);
    end

    // Slot response is selected through the held one-hot chipselect.
    always_comb begin
        slotReady = |(peri_ready & chipSel_q);
        slotRdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (chipSel_q[i]) slotRdata = slotRdata | peri_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        timeoutHit = (state_q == ACCESS) && !slotReady
                     && ((count_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
    end

    always_comb begin
        unique case (ctrlSel)
            2'd0:    ctrlRdata = DATA_WIDTH'(pending_q);
            2'd1:    ctrlRdata = DATA_WIDTH'(mask_q);
            2'd2:    ctrlRdata = DATA_WIDTH'(errAddr_q);
            default: ctrlRdata = DATA_WIDTH'(status_q);
        endcase
    end

    // Sticky status and pending latches: a set in the same cycle as a W1C clear wins.
    always_comb begin
        pendClr    = (ctrlWrite && ctrlSel == 2'd0) ? write_data[NUM_SLOTS-1:0] : '0;
        statClr    = (ctrlWrite && ctrlSel == 2'd3) ? write_data[2:0] : 3'b000;
        statSet[0] = idle && singleReq && !slotHit && !ctrlHit;
        statSet[1] = timeoutHit;
        statSet[2] = idle && bothReq;
        pending_d  = (pending_q & ~pendClr) | (peri_irq & ~irqPrev_q);
        status_d   = (status_q & ~statClr) | statSet;
        errAddr_d  = (state_q == ACCESS) ? capAddr_q : addr;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            capAddr_q   <= '0;
            errAddr_q   <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            irqPrev_q   <= '0;
            chipSel_q   <= '0;
            status_q    <= '0;
            readData_q  <= '0;
            periWdata_q <= '0;
            periAddr_q  <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            periWen_q   <= 1'b0;
            periRen_q   <= 1'b0;
        end else begin
            irqPrev_q <= peri_irq;
            pending_q <= pending_d;
            status_q  <= status_d;
            if (|statSet) errAddr_q <= errAddr_d;
            if (maskWrite) mask_q <= write_data[NUM_SLOTS-1:0];
            unique case (state_q)
                IDLE: begin
                    if (bothReq) begin
                        capAddr_q  <= addr;
                        state_q    <= DONE;
                        ready_q    <= 1'b1;
                        error_q    <= 1'b1;
                        readData_q <= '0;
                    end else if (singleReq) begin
                        capAddr_q   <= addr;
                        periAddr_q  <= addr[SLOT_ADDR_BITS-1:0];
                        periWdata_q <= write_data;
                        if (slotHit) begin
                            state_q   <= ACCESS;
                            count_q   <= '0;
                            chipSel_q <= slotOneHot;
                            periWen_q <= write_enable;
                            periRen_q <= read_enable;
                        end else begin
                            state_q    <= DONE;
                            ready_q    <= 1'b1;
                            error_q    <= !ctrlHit;
                            readData_q <= (ctrlHit && read_enable) ? ctrlRdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (slotReady || timeoutHit) begin
                        state_q    <= DONE;
                        ready_q    <= 1'b1;
                        error_q    <= !slotReady;
                        readData_q <= (slotReady && periRen_q) ? slotRdata : '0;
                        chipSel_q  <= '0;
                        periWen_q  <= 1'b0;
                        periRen_q  <= 1'b0;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ready_q    <= 1'b0;
                    error_q    <= 1'b0;
                    readData_q <= '0;
                end
            endcase
        end
    end

    assign read_data       = readData_q;
    assign ready           = ready_q;
    assign error           = error_q;
    assign irq             = |(pending_q & mask_q);
    assign peri_addr       = periAddr_q;
    assign peri_write_data = periWdata_q;
    assign peri_write_en   = periWen_q;
    assign peri_read_en    = periRen_q;
    assign peri_chipselect = chipSel_q;
endmodule

// File: tb/tb_peribus_hub.sv
// Self-checking bench for peribus_hub: a transaction-level model predicts every cycle's
// outputs, and directed accesses are also pinned against hand-computed literals.
module tb_peribus_hub;
    localparam int TIMEOUT = 15;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic [7:0]  addr;
    logic [15:0] write_data;
    logic        write_enable, read_enable;
    logic [15:0] read_data;
    logic        ready, error, irq;
    logic [1:0]  peri_addr;
    logic [15:0] peri_write_data;
    logic        peri_write_en, peri_read_en;
    logic [7:0]  peri_chipselect;
    logic [127:0] peri_read_data;
    logic [7:0]  peri_ready, peri_irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    peribus_hub dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .addr(addr), .write_data(write_data),
        .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
        .ready(ready), .error(error), .irq(irq), .peri_addr(peri_addr),
        .peri_write_data(peri_write_data), .peri_write_en(peri_write_en),
        .peri_read_en(peri_read_en), .peri_chipselect(peri_chipselect),
        .peri_read_data(peri_read_data), .peri_ready(peri_ready), .peri_irq(peri_irq)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Transaction-level model: each period it decides what a new or outstanding access
    // will return, and in which period the response and chipselect window fall.
    logic [7:0]  mPend = '0, mMask = '0, mPrevIrq = '0, mErrAddr = '0;
    logic [2:0]  mStatus = '0;
    int          respCyc = -1, csStart = 0, csEnd = 0;
    logic [7:0]  expCs = '0;
    logic        expWen = 1'b0, expRen = 1'b0, expErr = 1'b0;
    logic [15:0] expData = '0, expPwdata = '0;
    logic [1:0]  expPaddr = '0;
    bit          waiting = 0, waitRead = 0;
    int          waitStart = 0, waitSlot = 0;
    logic [7:0]  waitAddr = '0;

    always @(posedge CLOCK_50 or negedge reset_n) begin
        logic [7:0] clrPend, newMask;
        logic [2:0] clrStat, setStat;
        logic [15:0] ctrlVal;
        if (!reset_n) begin
            mPend = '0; mMask = '0; mPrevIrq = '0; mErrAddr = '0; mStatus = '0;
            respCyc = -1; csStart = 0; csEnd = 0; waiting = 0;
        end else begin
            clrPend = '0; clrStat = '0; setStat = '0; newMask = mMask;
            if (waiting) begin
                if (peri_ready[waitSlot]) begin
                    respCyc = cyc + 1; csEnd = cyc + 1; expErr = 1'b0; waiting = 0;
                    expData = waitRead ? peri_read_data[waitSlot*16 +: 16] : 16'h0;
                end else if (cyc - waitStart == TIMEOUT) begin
                    respCyc = cyc + 1; csEnd = cyc + 1; expErr = 1'b1; expData = '0;
                    setStat[1] = 1'b1; mErrAddr = waitAddr; waiting = 0;
                end
            end else if (cyc > respCyc && (read_enable || write_enable)) begin
                if (read_enable && write_enable) begin
                    respCyc = cyc + 1; expErr = 1'b1; expData = '0;
                    setStat[2] = 1'b1; mErrAddr = addr;
                end else if (addr < 8'd32) begin
                    waiting = 1; waitStart = cyc; waitSlot = addr / 4; waitAddr = addr;
                    waitRead = read_enable; csStart = cyc + 1; csEnd = 1 << 30;
                    expCs = 8'(1 << (addr / 4)); expWen = write_enable; expRen = read_enable;
                    expPaddr = addr[1:0]; expPwdata = write_data;
                end else if (addr >= 8'hF0 && addr <= 8'hF3) begin
                    case (addr - 8'hF0)
                        0: ctrlVal = {8'h0, mPend};
                        1: ctrlVal = {8'h0, mMask};
                        2: ctrlVal = {8'h0, mErrAddr};
                        default: ctrlVal = {13'h0, mStatus};
                    endcase
                    if (write_enable) begin
                        if (addr == 8'hF0) clrPend = write_data[7:0];
                        if (addr == 8'hF1) newMask = write_data[7:0];
                        if (addr == 8'hF3) clrStat = write_data[2:0];
                    end
                    respCyc = cyc + 1; expErr = 1'b0; expData = read_enable ? ctrlVal : 16'h0;
                end else begin
                    respCyc = cyc + 1; expErr = 1'b1; expData = '0;
                    setStat[0] = 1'b1; mErrAddr = addr;
                end
            end
            mPend = (mPend & ~clrPend) | (peri_irq & ~mPrevIrq);
            mStatus = (mStatus & ~clrStat) | setStat;
            mPrevIrq = peri_irq;
            mMask = newMask;
        end
    end

    // Compare every cycle on the falling edge, away from the DUT's active edge.
    always @(negedge CLOCK_50) begin
        bit expReady, csOn;
        expReady = (cyc == respCyc);
        csOn = (cyc >= csStart) && (cyc < csEnd);
        checkOutput("ready", ready, expReady);
        checkOutput("error", error, expReady ? expErr : 1'b0);
        if (expReady) checkOutput("read_data", read_data, expData);
        checkOutput("irq", irq, |(mPend & mMask));
        checkOutput("chipselect", peri_chipselect, csOn ? expCs : 8'h0);
        checkOutput("peri_write_en", peri_write_en, csOn ? expWen : 1'b0);
        checkOutput("peri_read_en", peri_read_en, csOn ? expRen : 1'b0);
        if (csOn) begin
            checkOutput("peri_addr", peri_addr, expPaddr);
            checkOutput("peri_write_data", peri_write_data, expPwdata);
        end
    end

    task automatic applyStimulus(input logic we, input logic re, input logic [7:0] a,
                                 input logic [15:0] wd, output int lat, output logic err,
                                 output logic [15:0] rd, output int strobeCycles,
                                 output logic [7:0] csAt1, output logic [1:0] paddrAt1);
        bit found;
        @(posedge CLOCK_50); #1;
        write_enable = we; read_enable = re; addr = a; write_data = wd;
        found = 0; lat = -1; err = 1'b0; rd = '0; strobeCycles = 0; csAt1 = '0; paddrAt1 = '0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge CLOCK_50);
            if (peri_write_en || peri_read_en) strobeCycles++;
            if (k == 1) begin csAt1 = peri_chipselect; paddrAt1 = peri_addr; end
            if (ready) begin
                found = 1; lat = k; err = error; rd = read_data;
            end else begin
                @(posedge CLOCK_50); #1;
                write_enable = 1'b0; read_enable = 1'b0;
            end
        end
        write_enable = 1'b0; read_enable = 1'b0;
        checkOutput("respTimeout", found, 1'b1);
    endtask

    task automatic doAccess(input string name, input logic we, input logic re, input logic [7:0] a,
                            input logic [15:0] wd, input int eLat, input logic eErr, input logic [15:0] eRd);
        int l, s;
        logic e;
        logic [15:0] r;
        logic [7:0] c;
        logic [1:0] p;
        applyStimulus(we, re, a, wd, l, e, r, s, c, p);
        checkOutput({name, "_latency"}, l, eLat);
        checkOutput({name, "_error"}, e, eErr);
        checkOutput({name, "_data"}, r, eRd);
    endtask

    int lat, strb;
    logic err;
    logic [15:0] rd;
    logic [7:0] cs1;
    logic [1:0] pa1;

    initial begin
        reset_n = 1'b0; write_enable = 1'b0; read_enable = 1'b0; addr = '0; write_data = '0;
        peri_ready = '0; peri_irq = '0;
        for (int i = 0; i < 8; i++) peri_read_data[i*16 +: 16] = 16'hA000 + 16'(i);
        peri_read_data[2*16 +: 16] = 16'hBEEF;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checkOutput("rstReady", ready, 1'b0);
        checkOutput("rstChipselect", peri_chipselect, 8'h0);
        checkOutput("rstIrq", irq, 1'b0);
        @(posedge CLOCK_50); #1; reset_n = 1'b1;

        $display("[TB] slot 2 read");
        peri_ready = 8'h04;
        applyStimulus(1'b0, 1'b1, 8'h09, 16'h0, lat, err, rd, strb, cs1, pa1);
        checkOutput("rd2_latency", lat, 2);
        checkOutput("rd2_error", err, 1'b0);
        checkOutput("rd2_data", rd, 16'hBEEF);
        checkOutput("rd2_cs", cs1, 8'h04);
        checkOutput("rd2_paddr", pa1, 2'd1);

        $display("[TB] slot 1 write with late ready");
        peri_ready = 8'h00;
        fork
            applyStimulus(1'b1, 1'b0, 8'h04, 16'h1234, lat, err, rd, strb, cs1, pa1);
            begin repeat (5) @(posedge CLOCK_50); #1; peri_ready[1] = 1'b1; end
        join
        peri_ready = 8'h00;
        checkOutput("wr1_latency", lat, 5);
        checkOutput("wr1_error", err, 1'b0);
        checkOutput("wr1_strobeCycles", strb, 4);

        $display("[TB] unmapped access and error registers");
        doAccess("unmapped", 1'b0, 1'b1, 8'h40, 16'h0, 1, 1'b1, 16'h0);
        doAccess("errAddr", 1'b0, 1'b1, 8'hF2, 16'h0, 1, 1'b0, 16'h0040);
        doAccess("status1", 1'b0, 1'b1, 8'hF3, 16'h0, 1, 1'b0, 16'h0001);
        doAccess("errAddrWr", 1'b1, 1'b0, 8'hF2, 16'hFFFF, 1, 1'b0, 16'h0);
        doAccess("errAddrKeep", 1'b0, 1'b1, 8'hF2, 16'h0, 1, 1'b0, 16'h0040);

        $display("[TB] slot 0 timeout");
        doAccess("timeout", 1'b0, 1'b1, 8'h00, 16'h0, TIMEOUT + 1, 1'b1, 16'h0);
        doAccess("status3", 1'b0, 1'b1, 8'hF3, 16'h0, 1, 1'b0, 16'h0003);
        doAccess("statusW1c", 1'b1, 1'b0, 8'hF3, 16'h0002, 1, 1'b0, 16'h0);
        doAccess("status1b", 1'b0, 1'b1, 8'hF3, 16'h0, 1, 1'b0, 16'h0001);
        doAccess("errAddr0", 1'b0, 1'b1, 8'hF2, 16'h0, 1, 1'b0, 16'h0000);

        $display("[TB] protocol error");
        doAccess("protocol", 1'b1, 1'b1, 8'h05, 16'h5555, 1, 1'b1, 16'h0);
        doAccess("status5", 1'b0, 1'b1, 8'hF3, 16'h0, 1, 1'b0, 16'h0005);

        $display("[TB] interrupt pending and mask");
        @(posedge CLOCK_50); #1; peri_irq = 8'h08;
        @(posedge CLOCK_50); #1; peri_irq = 8'h00;
        @(negedge CLOCK_50);
        checkOutput("irqMasked", irq, 1'b0);
        doAccess("pendRead", 1'b0, 1'b1, 8'hF0, 16'h0, 1, 1'b0, 16'h0008);
        doAccess("maskWide", 1'b1, 1'b0, 8'hF1, 16'hFFFF, 1, 1'b0, 16'h0);
        doAccess("maskRead", 1'b0, 1'b1, 8'hF1, 16'h0, 1, 1'b0, 16'h00FF);
        doAccess("maskSet", 1'b1, 1'b0, 8'hF1, 16'h0008, 1, 1'b0, 16'h0);
        @(negedge CLOCK_50);
        checkOutput("irqUnmasked", irq, 1'b1);
        doAccess("pendClr", 1'b1, 1'b0, 8'hF0, 16'h0008, 1, 1'b0, 16'h0);
        doAccess("pendCleared", 1'b0, 1'b1, 8'hF0, 16'h0, 1, 1'b0, 16'h0000);
        checkOutput("irqCleared", irq, 1'b0);
        fork
            doAccess("pendSetWins", 1'b1, 1'b0, 8'hF0, 16'h0008, 1, 1'b0, 16'h0);
            begin
                @(posedge CLOCK_50); #1; peri_irq = 8'h08;
                @(posedge CLOCK_50); #1; peri_irq = 8'h00;
            end
        join
        doAccess("pendKept", 1'b0, 1'b1, 8'hF0, 16'h0, 1, 1'b0, 16'h0008);
        @(negedge CLOCK_50);
        checkOutput("irqBeforeReset", irq, 1'b1);

        $display("[TB] reset during slot access");
        peri_ready = 8'h00;
        @(posedge CLOCK_50); #1; read_enable = 1'b1; addr = 8'h10;
        @(posedge CLOCK_50); #1; read_enable = 1'b0;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        checkOutput("csBeforeReset", peri_chipselect, 8'h10);
        reset_n = 1'b0;
        #1;
        checkOutput("rstMidCs", peri_chipselect, 8'h0);
        checkOutput("rstMidReadEn", peri_read_en, 1'b0);
        checkOutput("rstMidWriteEn", peri_write_en, 1'b0);
        checkOutput("rstMidReady", ready, 1'b0);
        checkOutput("rstMidIrq", irq, 1'b0);
        @(posedge CLOCK_50); #1; reset_n = 1'b1;
        doAccess("statusAfterRst", 1'b0, 1'b1, 8'hF3, 16'h0, 1, 1'b0, 16'h0000);
        doAccess("maskAfterRst", 1'b0, 1'b1, 8'hF1, 16'h0, 1, 1'b0, 16'h0000);
        peri_ready = 8'h04;
        doAccess("readAfterRst", 1'b0, 1'b1, 8'h09, 16'h0, 2, 1'b0, 16'hBEEF);

        repeat (2) @(posedge CLOCK_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/peribus_hub.md
Name: peribus_hub

Overview:
Parametrised Peribus controller that sits between the CPU memory interface and up to NUM_SLOTS peripherals. It decodes fixed-size address windows, drives registered chipselect/strobe lines, and waits on per-slot ready with a timeout. It returns registered read data with a ready/error handshake. It also provides an interrupt aggregator with rising-edge pending latches, a mask register, and sticky bus-error status.

Parameters:
NUM_SLOTS, 8, number of peripheral slots (1..DATA_WIDTH)
SLOT_ADDR_BITS, 2, register address bits per slot; each window is 2**SLOT_ADDR_BITS words
ADDR_WIDTH, 8, host address width
DATA_WIDTH, 16, data word width
CTRL_BASE, 'hF0, base of the 4-word local control block; must not overlap any slot window
TIMEOUT_CYCLES, 15, ACCESS cycles allowed before a timeout error (>=1)

Ports:
CLOCK_50  in  1  bus clock; all logic rises on this edge
reset_n  in  1  asynchronous active-low reset
addr  in  ADDR_WIDTH  host address, sampled with the request strobe
write_data  in  DATA_WIDTH  host write data, sampled with the request strobe
write_enable  in  1  single-cycle write request strobe
read_enable  in  1  single-cycle read request strobe
read_data  out  DATA_WIDTH  registered read data, valid only while ready=1
ready  out  1  one-cycle completion pulse
error  out  1  asserted with ready when the access failed
irq  out  1  OR of (pending & mask)
peri_addr  out  SLOT_ADDR_BITS  captured addr low bits
peri_write_data  out  DATA_WIDTH  captured write data
peri_write_en  out  1  held high through ACCESS for writes
peri_read_en  out  1  held high through ACCESS for reads
peri_chipselect  out  NUM_SLOTS  one-hot; held through ACCESS
peri_read_data  in  NUM_SLOTS*DATA_WIDTH  packed; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
peri_ready  in  NUM_SLOTS  per-slot access-complete
peri_irq  in  NUM_SLOTS  level interrupt request, synchronous to CLOCK_50

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0. The irq output is 0 because pending and mask are both 0.
  - Timeout counter, STATUS, ERR_ADDR and the irq edge registers are cleared to 0.
- Address map:
  - Slot i covers [i<<SLOT_ADDR_BITS, (i+1)<<SLOT_ADDR_BITS).
  - Control block: CTRL_BASE+0 IRQ_PENDING (W1C), +1 IRQ_MASK (RW), +2 ERR_ADDR (RO, zero-extended), +3 STATUS (W1C). STATUS bit0 = unmapped, bit1 = timeout, bit2 = protocol.
  - Any other address is unmapped.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - On read_enable XOR write_enable, capture addr and write_data.
  - Slot hit: go to ACCESS and drive the one-hot chipselect plus the matching strobe starting the next cycle.
  - Control-block hit or unmapped: go straight to DONE.
  - read_enable AND write_enable together: go to DONE with a protocol error.
- ACCESS:
  - Each cycle, sample peri_ready[slot].
  - If high: register that slot's peri_read_data (writes return 0) and go to DONE.
  - Otherwise increment the counter. When the counter == TIMEOUT_CYCLES, go to DONE with a timeout error.
  - Chipselect and strobes drop on exit.
- DONE: ready=1 for exactly one cycle, then return to IDLE.
- Latency:
  - Slot access: strobe at cycle 0, chipselect at cycle 1; with peri_ready already high, ready occurs at cycle 2.
  - Control/unmapped/protocol: ready at cycle 1.
  - Timeout: ready at cycle TIMEOUT_CYCLES+1.
- Strobes arriving while not in IDLE are ignored. They are not queued and produce no response.
- Error response:
  - error=1, read_data=0, and no side effect on any register.
  - ERR_ADDR <= captured addr.
  - The matching STATUS bit is set and is sticky.
- Writes to ERR_ADDR are ignored and complete without error.
- Reads of unused control bits return 0.
- IRQ pending:
  - pending[i] sets on a rising edge of peri_irq[i] (previous value registered).
  - Write 1 to IRQ_PENDING clears the corresponding bits.
  - If a set and a clear hit the same bit in the same cycle, the set wins. STATUS W1C follows the same rule.
- irq is combinational from the pending and mask registers. A masked pending bit stays latched and raises irq when it is later unmasked.
- Register bits at index >= NUM_SLOTS read 0 and ignore writes.

Test Plan:
- Read slot 2 (addr='h09) with peri_ready[2]=1 and slot data 'hBEEF -> peri_chipselect='b00000100 and peri_addr=1 at cycle 1; ready=1, error=0, read_data='hBEEF at cycle 2.
- Write 'h1234 to addr 'h04 with peri_ready[1] raised 3 cycles late -> peri_write_en held 4 cycles; ready at cycle 5; error=0.
- Read addr 'h40 (unmapped) -> ready+error at cycle 1, read_data=0; then read CTRL_BASE+2 -> 'h0040 and CTRL_BASE+3 -> 'h0001.
- Read slot 0 with peri_ready held low -> error at cycle 16 (TIMEOUT_CYCLES=15); STATUS bit1=1; write 'h2 to STATUS clears it.
- Pulse peri_irq[3] with mask=0 -> irq=0 and pending='h08; write mask 'h08 -> irq=1; W1C 'h08 coinciding with a new peri_irq[3] edge -> pending stays 'h08.
- Assert reset_n=0 mid-ACCESS -> chipselect, strobes, ready, irq, STATUS and mask are 0 immediately; the next request is accepted normally.
